timer_alarm_core: RTL and testbench

Countdown alarm companion to timer_core. timer_core counts elapsed time up and is sampled; this block loads a target interval, counts it down and raises an interrupt on expiry. It supports one-shot and periodic reload, with a sticky IRQ, acknowledge and overrun flag. It sits beside timer_core under the same peripheral wrapper, and the register interface drives it with single-cycle strobes.

---
 rtl/alarm_pkg.sv | 14 +
 rtl/alarm_prescaler.sv | 37 +++
 rtl/timer_alarm_core.sv | 128 ++++++++++++
 tb/tb_timer_alarm_core.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared state encoding and default widths for the countdown alarm.
// Optional prescaler is enabled with macro ALARM_PRESCALER_EN.
package alarm_pkg;

    localparam int ALARM_COUNT_W    = 64;
    localparam int ALARM_PRESCALE_W = 8;

    typedef enum logic [1:0] {
        ALARM_IDLE    = 2'd0,
        ALARM_RUN     = 2'd1,
        ALARM_EXPIRED = 2'd2
    } alarm_state_e;

endpackage

// File: rtl/alarm_prescaler.sv
// Enabled-cycle divider: one tick every DIV+1 enabled cycles.
// Instantiated by timer_alarm_core only under ALARM_PRESCALER_EN.
module alarm_prescaler
    import alarm_pkg::*;
#(
    parameter int PRESCALE_W = ALARM_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] div_q;

    assign tick = enable && (cnt_q >= div_q);

    // div is re-sampled only at a wrap or restart
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            div_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
            div_q <= div;
        end else if (tick) begin
            cnt_q <= '0;
            div_q <= div;
        end else if (enable) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/timer_alarm_core.sv
// Countdown alarm: one-shot or periodic reload, sticky IRQ and overrun.
// Define ALARM_PRESCALER_EN to add the ALARM_DIV tick prescaler.
module timer_alarm_core
    import alarm_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int COUNT_W = 2 * DATA_W
`ifdef ALARM_PRESCALER_EN
    ,
    parameter int PRESCALE_W = ALARM_PRESCALE_W
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ALARM_ENABLE,
    input  logic               ALARM_LOAD,
    input  logic [COUNT_W-1:0] ALARM_VALUE,
    input  logic               ALARM_PERIODIC,
    input  logic               ALARM_ACK,
`ifdef ALARM_PRESCALER_EN
    input  logic [PRESCALE_W-1:0] ALARM_DIV,
`endif
    output logic [COUNT_W-1:0] ALARM_COUNT,
    output logic               ALARM_BUSY,
    output logic               ALARM_IRQ,
    output logic               ALARM_OVERRUN
);

    alarm_state_e       state_q, state_n;
    logic [COUNT_W-1:0] count_q, count_n;
    logic [COUNT_W-1:0] reload_q, reload_n;
    logic               periodic_q, periodic_n;
    logic               irq_q, irq_n;
    logic               ovr_q, ovr_n;
    logic               busy_q;
    logic               tick;
    logic               expire;

`ifdef ALARM_PRESCALER_EN
    alarm_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .enable(ALARM_ENABLE),
        .clear (ALARM_LOAD),
        .div   (ALARM_DIV),
        .tick  (tick)
    );
`else
    assign tick = ALARM_ENABLE;
`endif

    always_comb begin
        state_n    = state_q;
        count_n    = count_q;
        reload_n   = reload_q;
        periodic_n = periodic_q;
        irq_n      = irq_q;
        ovr_n      = ovr_q;
        expire     = 1'b0;

        if (ALARM_LOAD) begin
            reload_n   = ALARM_VALUE;
            count_n    = ALARM_VALUE;
            periodic_n = ALARM_PERIODIC;
            state_n    = (ALARM_VALUE != '0) ? ALARM_RUN : ALARM_IDLE;
        end else begin
            unique case (state_q)
                ALARM_RUN: begin
                    if (tick) begin
                        if (count_q > COUNT_W'(1)) begin
                            count_n = count_q - COUNT_W'(1);
                        end else begin
                            expire = 1'b1;
                            if (periodic_q) begin
                                count_n = reload_q;
                            end else begin
                                count_n = '0;
                                state_n = ALARM_EXPIRED;
                            end
                        end
                    end
                end
                ALARM_EXPIRED: count_n = '0;
                default: ;
            endcase
        end

        // a fresh expiry outranks a same-cycle acknowledge
        if (expire) begin
            irq_n = 1'b1;
            if (ALARM_ACK)
                ovr_n = 1'b0;
            else if (irq_q)
                ovr_n = 1'b1;
        end else if (ALARM_ACK) begin
            irq_n = 1'b0;
            ovr_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ALARM_IDLE;
            count_q    <= '0;
            reload_q   <= '0;
            periodic_q <= 1'b0;
            irq_q      <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            count_q    <= count_n;
            reload_q   <= reload_n;
            periodic_q <= periodic_n;
            irq_q      <= irq_n;
            ovr_q      <= ovr_n;
            busy_q     <= (state_n == ALARM_RUN);
        end
    end

    assign ALARM_COUNT   = count_q;
    assign ALARM_BUSY    = busy_q;
    assign ALARM_IRQ     = irq_q;
    assign ALARM_OVERRUN = ovr_q;

endmodule

// File: tb/tb_timer_alarm_core.sv
// Randomised and directed bench for timer_alarm_core against an
// elapsed-tick reference model.
module tb_timer_alarm_core;

    localparam int CW = 64;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          ld;
    logic [CW-1:0] val;
    logic          per;
    logic          ack;
    logic [CW-1:0] cnt;
    logic          busy;
    logic          irq;
    logic          ovr;
`ifdef ALARM_PRESCALER_EN
    logic [7:0]    div;
`endif

    int n_chk;
    int n_fail;

    // reference model: ticks elapsed since the last load
    logic [CW-1:0] m_n;
    logic [CW-1:0] m_el;
    logic          m_per;
    logic          m_act;
    logic          m_irq;
    logic          m_ovr;

    timer_alarm_core dut (
        .clk           (clk),
        .rst           (rst_n),
        .ALARM_ENABLE  (en),
        .ALARM_LOAD    (ld),
        .ALARM_VALUE   (val),
        .ALARM_PERIODIC(per),
        .ALARM_ACK     (ack),
`ifdef ALARM_PRESCALER_EN
        .ALARM_DIV     (div),
`endif
        .ALARM_COUNT   (cnt),
        .ALARM_BUSY    (busy),
        .ALARM_IRQ     (irq),
        .ALARM_OVERRUN (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [CW-1:0] obs,
                         input logic [CW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n = '0; m_el = '0; m_per = 1'b0;
        m_act = 1'b0; m_irq = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic model_edge(input logic e, input logic l,
                              input logic [CW-1:0] v, input logic p,
                              input logic a);
        logic ev;
        ev = 1'b0;
        if (l) begin
            m_n = v; m_per = p; m_el = '0; m_act = (v != '0);
        end else if (m_act && e && (m_per || m_el < m_n)) begin
            m_el = m_el + 1;
            ev = m_per ? (m_el % m_n == 0) : (m_el == m_n);
        end
        if (ev) begin
            if (a) m_ovr = 1'b0;
            else if (m_irq) m_ovr = 1'b1;
            m_irq = 1'b1;
        end else if (a) begin
            m_irq = 1'b0; m_ovr = 1'b0;
        end
    endtask

    function automatic logic [CW-1:0] m_count();
        if (m_n == '0) return '0;
        if (m_per) return m_n - (m_el % m_n);
        return (m_el >= m_n) ? '0 : m_n - m_el;
    endfunction

    function automatic logic m_busy();
        return m_act && (m_per || m_el < m_n);
    endfunction

    task automatic compare_all();
        check("count", cnt, m_count());
        check("busy", CW'(busy), CW'(m_busy()));
        check("irq", CW'(irq), CW'(m_irq));
        check("overrun", CW'(ovr), CW'(m_ovr));
    endtask

    task automatic step(input logic e, input logic l, input logic [CW-1:0] v,
                        input logic p, input logic a);
        en = e; ld = l; val = v; per = p; ack = a;
        @(posedge clk);
        model_edge(e, l, v, p, a);
        #1;
        compare_all();
    endtask

    task automatic run(input int n, input logic e);
        for (int i = 0; i < n; i++) step(e, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [CW-1:0] maxv;
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; en = 1'b0; ld = 1'b0; val = '0; per = 1'b0; ack = 1'b0;
`ifdef ALARM_PRESCALER_EN
        div = '0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // one-shot 1000
        step(1, 1, 64'd1000, 0, 0);
        check("os_busy", CW'(busy), 64'd1);
        run(999, 1);
        check("os_irq_early", CW'(irq), 64'd0);
        run(1, 1);
        check("os_irq", CW'(irq), 64'd1);
        check("os_count", cnt, 64'd0);
        check("os_busy_end", CW'(busy), 64'd0);
        run(3, 1);
        check("os_hold", cnt, 64'd0);

        // periodic 5 with ack, then overrun
        step(1, 0, '0, 0, 1);
        step(1, 1, 64'd5, 1, 0);
        run(5, 1);
        check("per_irq1", CW'(irq), 64'd1);
        step(1, 0, '0, 0, 1);
        check("per_ack", CW'(irq), 64'd0);
        run(4, 1);
        check("per_irq2", CW'(irq), 64'd1);
        run(5, 1);
        check("per_ovr", CW'(ovr), 64'd1);
        step(1, 0, '0, 0, 1);

        // enable freeze
        step(1, 1, 64'd10, 0, 0);
        run(3, 1);
        run(20, 0);
        check("freeze_cnt", cnt, 64'd7);
        run(6, 1);
        check("freeze_noirq", CW'(irq), 64'd0);
        run(1, 1);
        check("freeze_irq", CW'(irq), 64'd1);
        step(1, 0, '0, 0, 1);

        // restart mid-countdown
        step(1, 1, 64'd50, 0, 0);
        run(30, 1);
        check("rl_cnt20", cnt, 64'd20);
        step(1, 1, 64'd8, 0, 0);
        check("rl_cnt8", cnt, 64'd8);
        run(7, 1);
        check("rl_noirq", CW'(irq), 64'd0);
        run(1, 1);
        check("rl_irq", CW'(irq), 64'd1);

        // expiry + ack on the same edge, then load 0
        step(1, 1, 64'd4, 1, 0);
        run(3, 1);
        step(1, 0, '0, 0, 1);
        check("same_irq", CW'(irq), 64'd1);
        check("same_ovr", CW'(ovr), 64'd0);
        step(1, 1, 64'd0, 0, 0);
        check("zero_busy", CW'(busy), 64'd0);
        check("zero_irq", CW'(irq), 64'd1);
        step(1, 0, '0, 0, 1);

        // maximum interval
        maxv = '1;
        step(1, 1, maxv, 0, 0);
        run(3, 1);
        check("max_cnt", cnt, maxv - 64'd3);

        // asynchronous reset mid-run
        step(1, 1, 64'd500, 0, 0);
        run(200, 1);
        check("pre_rst", cnt, 64'd300);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic l;
            l = ($urandom_range(0, 19) == 0);
            step($urandom_range(0, 9) < 8, l, CW'($urandom_range(0, 12)),
                 1'($urandom), $urandom_range(0, 9) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
